fc_decision_buffer: RTL and testbench
=====================================

Name: fc_decision_buffer

Overview:
- Downstream stage of the final fully-connected (linear) layer in the GRU equalizer.
- On each upstream trigger (GRU hidden state ready), drives the linear layer's level start/done handshake and captures the 32-bit soft prediction.
- Slices the prediction to a PAM-4 symbol index and buffers {soft, symbol} in a show-ahead FIFO, which is read through a valid/ready interface.

Parameters:
- DATA_WIDTH, 32, prediction width; two's-complement fixed point.
- FRAC_BITS, 16, fractional bits of the prediction (documentation and bench only).
- THRESH, 32'h0002_0000, outer PAM-4 decision threshold (+2.0 in Q16.16); positive.
- FIFO_DEPTH, 8, entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- i_trigger  in  1  request one prediction; sampled only while o_trig_ready=1
- o_trig_ready  out  1  high in S_IDLE when FIFO count < FIFO_DEPTH
- o_fc_start  out  1  start level to the linear layer
- i_fc_done  in  1  done level from the linear layer
- i_fc_prediction  in  DATA_WIDTH  linear layer result; valid while i_fc_done=1
- o_valid  out  1  FIFO non-empty
- i_ready  in  1  consumer accepts head entry
- o_soft  out  DATA_WIDTH  head entry soft value
- o_symbol  out  2  head entry PAM-4 index
- o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_overflow  out  1  sticky: i_trigger seen while o_trig_ready=0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rstn).
- Reset values: all outputs 0, FSM in S_IDLE, FIFO pointers and count 0.
- Reset mid-operation: abort; o_fc_start drops immediately and the FIFO contents are discarded.

FSM states:
- S_IDLE: if i_trigger && o_trig_ready, go to S_START.
- S_START: o_fc_start<=1; go to S_WAIT_DONE.
- S_WAIT_DONE: hold o_fc_start=1. When i_fc_done=1: latch i_fc_prediction into soft_q, o_fc_start<=0, go to S_WAIT_ACK.
- S_WAIT_ACK: o_fc_start=0. When i_fc_done=0, go to S_SLICE.
- S_SLICE: compute sym_q from soft_q (registered); go to S_PUSH.
- S_PUSH: write {soft_q, sym_q} to the FIFO tail; go to S_IDLE.

Handshake and latency:
- o_trig_ready is registered-state based: it is 1 only in S_IDLE, so one prediction is in flight at a time.
- The slot is guaranteed at S_PUSH because count can only fall after acceptance.
- If i_fc_done is already high on entering S_WAIT_DONE, capture occurs in that same cycle.
- Trigger to o_valid is 5 cycles plus the linear layer's done latency plus its done-deassert latency.

Slicer (signed compare):
- soft < -THRESH → 0
- -THRESH ≤ soft < 0 → 1
- 0 ≤ soft < THRESH → 2
- soft ≥ THRESH → 3
- The full DATA_WIDTH compare is used; no saturation is needed.

FIFO:
- Show-ahead: o_soft/o_symbol reflect the head entry whenever o_valid=1; they are don't-care otherwise.
- Pop occurs when o_valid && i_ready. Pop while empty is ignored.
- Push and pop in the same cycle leave count unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Full (count==FIFO_DEPTH): o_trig_ready=0. i_trigger in that state sets o_overflow, which is cleared only by reset.

Decomposition:
- Shared package: S_* state encodings (4-bit localparams), PAM-4 symbol index constants (SYM_M3=0, SYM_M1=1, SYM_P1=2, SYM_P3=3), and default THRESH.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; show-ahead; count output), instantiated with WIDTH=DATA_WIDTH+2.
- The FSM and slicer stay in the top level.

Test Plan:
- Single trigger; linear-layer model returns done after 4 cycles with 32'h0000_8000 (+0.5) → exactly one o_fc_start pulse-train ending when done is seen; o_valid after the done-deassert path; o_soft=32'h0000_8000, o_symbol=2; o_count=1.
- Slicer boundaries via successive predictions of 32'hFFFD_0000 (-3.0), 32'hFFFE_0000 (-2.0), 32'hFFFF_0000 (-1.0), 32'h0000_0000, 32'h0002_0000 (+2.0) → symbols 0, 1, 1, 2, 3, in order.
- i_ready held 0 with 8 triggers → o_count=8, o_trig_ready=0; a 9th i_trigger sets o_overflow=1 with no o_fc_start; then one pop → o_trig_ready=1, and o_overflow stays 1.
- Push and pop same cycle with count=3 → count stays 3, and head order is preserved (FIFO order check over 20 random values).
- Done already high one cycle after start → capture on the first S_WAIT_DONE cycle; FSM waits in S_WAIT_ACK until the model drops done, with o_fc_start=0 throughout.
- rstn asserted low during S_WAIT_DONE → o_fc_start=0 immediately, o_valid=0, o_count=0, o_overflow=0; a post-reset trigger completes normally.

Source files
------------

// File: rtl/fc_decision_buffer_pkg.sv
// Shared definitions for the FC-layer decision buffer: FSM states,
// PAM-4 symbol indices and the default outer decision threshold.
package fc_decision_buffer_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_WAIT_DONE = 4'd2,
    S_WAIT_ACK  = 4'd3,
    S_SLICE     = 4'd4,
    S_PUSH      = 4'd5
  } fc_state_e;

  localparam logic [1:0] SYM_M3 = 2'd0;
  localparam logic [1:0] SYM_M1 = 2'd1;
  localparam logic [1:0] SYM_P1 = 2'd2;
  localparam logic [1:0] SYM_P3 = 2'd3;

  // +2.0 in Q16.16
  localparam logic [31:0] THRESH_DEFAULT = 32'h0002_0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; head entry is
// presented combinationally and reads as zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             push;
  logic             pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates everything visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/fc_decision_buffer.sv
// Sequences the final linear layer start/done handshake, slices the soft
// prediction to a PAM-4 index and queues {soft, symbol} for the consumer.
module fc_decision_buffer
  import fc_decision_buffer_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FRAC_BITS  = 16,
  parameter logic [DATA_WIDTH-1:0] THRESH     = DATA_WIDTH'(THRESH_DEFAULT),
  parameter int unsigned           FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_trigger,
  output logic                          o_trig_ready,
  output logic                          o_fc_start,
  input  logic                          i_fc_done,
  input  logic [DATA_WIDTH-1:0]         i_fc_prediction,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_WIDTH-1:0]         o_soft,
  output logic [1:0]                    o_symbol,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW = DATA_WIDTH + 2;
  localparam logic signed [DATA_WIDTH-1:0] THR_POS = THRESH;
  localparam logic signed [DATA_WIDTH-1:0] THR_NEG = -THRESH;

  if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_BITS must be smaller than DATA_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  fc_state_e             state_q, state_d;
  logic                  fc_start_q, fc_start_d;
  logic                  trig_ready_q, trig_ready_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] soft_q, soft_d;
  logic [1:0]            sym_q, sym_d;
  logic [1:0]            slice_sym;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [FW-1:0]         fifo_rd_data;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         count_next;

  always_comb begin
    slice_sym = SYM_P3;
    if ($signed(soft_q) < THR_NEG) begin
      slice_sym = SYM_M3;
    end else if ($signed(soft_q) < 0) begin
      slice_sym = SYM_M1;
    end else if ($signed(soft_q) < THR_POS) begin
      slice_sym = SYM_P1;
    end
  end

  assign fifo_push = (state_q == S_PUSH);
  assign fifo_pop  = !fifo_empty && i_ready;

  // Ready is registered, so it is precomputed from next state and next occupancy.
  always_comb begin
    count_next = fifo_count;
    if (fifo_push && !fifo_pop) begin
      count_next = fifo_count + 1'b1;
    end else if (!fifo_push && fifo_pop) begin
      count_next = fifo_count - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fc_start_d = fc_start_q;
    soft_d     = soft_q;
    sym_d      = sym_q;
    overflow_d = overflow_q | (i_trigger & ~trig_ready_q);
    case (state_q)
      S_IDLE: begin
        fc_start_d = 1'b0;
        if (i_trigger && trig_ready_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        fc_start_d = 1'b1;
        state_d    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        fc_start_d = 1'b1;
        if (i_fc_done) begin
          soft_d     = i_fc_prediction;
          fc_start_d = 1'b0;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        fc_start_d = 1'b0;
        if (!i_fc_done) begin
          state_d = S_SLICE;
        end
      end
      S_SLICE: begin
        sym_d   = slice_sym;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        fc_start_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
    trig_ready_d = (state_d == S_IDLE) && (count_next < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      fc_start_q   <= 1'b0;
      trig_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
      soft_q       <= '0;
      sym_q        <= '0;
    end else begin
      state_q      <= state_d;
      fc_start_q   <= fc_start_d;
      trig_ready_q <= trig_ready_d;
      overflow_q   <= overflow_d;
      soft_q       <= soft_d;
      sym_q        <= sym_d;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (fifo_push),
    .wr_data ({soft_q, sym_q}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign o_trig_ready = trig_ready_q;
  assign o_fc_start   = fc_start_q;
  assign o_overflow   = overflow_q;
  assign o_valid      = !fifo_empty;
  assign o_soft       = fifo_rd_data[FW-1:2];
  assign o_symbol     = fifo_rd_data[1:0];
  assign o_count      = fifo_count;

endmodule

// File: tb/tb_fc_decision_buffer.sv
// Randomized bench for fc_decision_buffer: a linear-layer responder model
// plus a queue-based reference for FIFO contents and PAM-4 decisions.
module tb_fc_decision_buffer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_trigger = 1'b0;
  logic        i_fc_done = 1'b0;
  logic [31:0] i_fc_prediction = '0;
  logic        i_ready = 1'b0;
  logic        o_trig_ready, o_fc_start, o_valid, o_overflow;
  logic [31:0] o_soft;
  logic [1:0]  o_symbol;
  logic [3:0]  o_count;

  int tests_run = 0;
  int fails = 0;

  // responder controls: done after m_dl cycles, drop done m_al cycles after start falls
  int          m_dl = 0, m_al = 0, m_phase = 0, m_cnt = 0;
  logic [31:0] m_pred = '0;
  logic [33:0] exp_q[$];

  fc_decision_buffer #(
    .DATA_WIDTH (32),
    .FRAC_BITS  (16),
    .THRESH     (32'h0002_0000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_trigger       (i_trigger),
    .o_trig_ready    (o_trig_ready),
    .o_fc_start      (o_fc_start),
    .i_fc_done       (i_fc_done),
    .i_fc_prediction (i_fc_prediction),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_soft          (o_soft),
    .o_symbol        (o_symbol),
    .o_count         (o_count),
    .o_overflow      (o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_sym(input logic [31:0] v);
    int s;
    s = $signed(v);
    if (s < -(2 * 65536)) return 2'd0;
    if (s < 0) return 2'd1;
    if (s < 2 * 65536) return 2'd2;
    return 2'd3;
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!i_fc_done) i_fc_prediction = $urandom;
      if (!rstn) begin
        m_phase = 0; i_fc_done = 1'b0;
      end else begin
        case (m_phase)
          0: if (o_fc_start) begin
               if (m_dl == 0) begin i_fc_done = 1'b1; i_fc_prediction = m_pred; m_phase = 2; end
               else begin m_cnt = m_dl; m_phase = 1; end
             end
          1: begin
               m_cnt--;
               if (m_cnt == 0) begin i_fc_done = 1'b1; i_fc_prediction = m_pred; m_phase = 2; end
             end
          2: if (!o_fc_start) begin
               i_fc_prediction = $urandom;
               if (m_al == 0) begin i_fc_done = 1'b0; m_phase = 0; end
               else begin m_cnt = m_al; m_phase = 3; end
             end
          default: begin
               m_cnt--;
               if (m_cnt == 0) begin i_fc_done = 1'b0; m_phase = 0; end
             end
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic run_trig(input logic [31:0] pred, input int dl, input int al,
                          input bit pop_at_push, output bit popped, output logic [33:0] head);
    popped = 1'b0;
    head = '0;
    for (int k = 0; k < 40 && !o_trig_ready; k++) begin @(posedge clk); #1; end
    if (!o_trig_ready) begin
      tests_run++; fails++;
      $display("FAIL trig_ready_wait got=0 want=1");
    end
    m_dl = dl; m_al = al; m_pred = pred;
    i_trigger = 1'b1;
    @(posedge clk); #1;
    i_trigger = 1'b0;
    exp_q.push_back({pred, ref_sym(pred)});
    for (int n = 1; n <= 5 + dl + al; n++) begin
      if (pop_at_push && n == 5 + dl + al && o_valid) begin
        i_ready = 1'b1; head = {o_soft, o_symbol}; popped = 1'b1;
      end
      @(posedge clk); #1;
      i_ready = 1'b0;
    end
  endtask

  task automatic do_pop(output logic [33:0] head);
    head = {o_soft, o_symbol};
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if ({o_trig_ready, o_fc_start, o_valid, o_overflow, o_count, o_soft, o_symbol} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%0h want=0",
               {o_trig_ready, o_fc_start, o_valid, o_overflow, o_count, o_soft, o_symbol});
    end
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (o_trig_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", o_trig_ready); end
  endtask

  task automatic test_single;
    int lat, hi, rises;
    logic prev;
    logic [33:0] h;
    m_dl = 4; m_al = 2; m_pred = 32'h0000_8000;
    i_trigger = 1'b1;
    @(posedge clk); #1;
    i_trigger = 1'b0;
    exp_q.push_back({m_pred, ref_sym(m_pred)});
    lat = 0; hi = 0; rises = 0; prev = o_fc_start;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (o_fc_start) hi++;
      if (o_fc_start && !prev) rises++;
      prev = o_fc_start;
    end
    tests_run++; if (lat != 11) begin fails++; $display("FAIL single_latency got=%0d want=11", lat); end
    tests_run++; if (hi != 5 || rises != 1) begin fails++; $display("FAIL single_start got=%0d/%0d want=5/1", hi, rises); end
    tests_run++; if (o_soft !== 32'h0000_8000) begin fails++; $display("FAIL single_soft got=%h want=00008000", o_soft); end
    tests_run++; if (o_symbol !== 2'd2) begin fails++; $display("FAIL single_symbol got=%0d want=2", o_symbol); end
    tests_run++; if (o_count !== 4'd1) begin fails++; $display("FAIL single_count got=%0d want=1", o_count); end
    do_pop(h);
    void'(exp_q.pop_front());
    tests_run++;
    if (o_valid !== 1'b0 || o_count !== 4'd0) begin
      fails++; $display("FAIL single_pop got=%b/%0d want=0/0", o_valid, o_count);
    end
  endtask

  task automatic test_slicer;
    logic [31:0] preds [8];
    logic [1:0]  syms  [8];
    logic [33:0] h;
    bit p;
    preds = '{32'hFFFD_0000, 32'hFFFE_0000, 32'hFFFF_0000, 32'h0000_0000,
              32'h0002_0000, 32'h0001_FFFF, 32'hFFFD_FFFF, 32'hFFFF_FFFF};
    syms  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 8; i++) run_trig(preds[i], $urandom_range(3, 0), $urandom_range(3, 0), 1'b0, p, h);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (!o_valid || {o_soft, o_symbol} !== {preds[i], syms[i]}) begin
        fails++; $display("FAIL slicer_%0d got=%h/%0d want=%h/%0d", i, o_soft, o_symbol, preds[i], syms[i]);
      end
      do_pop(h);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_full_overflow;
    logic [33:0] h, e;
    bit p;
    int hi;
    for (int i = 0; i < 8; i++) run_trig($urandom, $urandom_range(3, 0), $urandom_range(3, 0), 1'b0, p, h);
    tests_run++;
    if (o_count !== 4'd8 || o_trig_ready !== 1'b0 || o_overflow !== 1'b0) begin
      fails++; $display("FAIL full_state got=%0d/%b/%b want=8/0/0", o_count, o_trig_ready, o_overflow);
    end
    i_trigger = 1'b1;
    @(posedge clk); #1;
    i_trigger = 1'b0;
    hi = 0;
    for (int i = 0; i < 8; i++) begin if (o_fc_start) hi++; @(posedge clk); #1; end
    tests_run++; if (hi != 0) begin fails++; $display("FAIL overflow_no_start got=%0d want=0", hi); end
    tests_run++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL overflow_set got=%b want=1", o_overflow); end
    do_pop(h);
    e = exp_q.pop_front();
    tests_run++; if (h !== e) begin fails++; $display("FAIL full_head got=%h want=%h", h, e); end
    tests_run++;
    if (o_trig_ready !== 1'b1 || o_overflow !== 1'b1 || o_count !== 4'd7) begin
      fails++; $display("FAIL after_pop got=%b/%b/%0d want=1/1/7", o_trig_ready, o_overflow, o_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (!o_valid || {o_soft, o_symbol} !== e) begin
        fails++; $display("FAIL full_drain got=%h want=%h", {o_soft, o_symbol}, e);
      end
      do_pop(h);
    end
  endtask

  task automatic test_push_pop;
    logic [33:0] h, e;
    bit p;
    for (int i = 0; i < 3; i++) run_trig($urandom, $urandom_range(3, 0), $urandom_range(3, 0), 1'b0, p, h);
    for (int i = 0; i < 17; i++) begin
      run_trig($urandom, $urandom_range(3, 0), $urandom_range(3, 0), 1'b1, p, h);
      e = exp_q.pop_front();
      tests_run++;
      if (!p || h !== e || o_count !== 4'd3) begin
        fails++; $display("FAIL push_pop_%0d got=%h/%0d want=%h/3", i, h, o_count, e);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (!o_valid || {o_soft, o_symbol} !== e) begin
        fails++; $display("FAIL push_pop_drain got=%h want=%h", {o_soft, o_symbol}, e);
      end
      do_pop(h);
    end
  endtask

  task automatic test_done_early;
    int lat, hi;
    logic [33:0] h;
    m_dl = 0; m_al = 5; m_pred = $urandom;
    i_trigger = 1'b1;
    @(posedge clk); #1;
    i_trigger = 1'b0;
    lat = 0; hi = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (o_fc_start) hi++;
    end
    tests_run++; if (lat != 10) begin fails++; $display("FAIL early_latency got=%0d want=10", lat); end
    tests_run++; if (hi != 1) begin fails++; $display("FAIL early_start got=%0d want=1", hi); end
    tests_run++;
    if ({o_soft, o_symbol} !== {m_pred, ref_sym(m_pred)}) begin
      fails++; $display("FAIL early_capture got=%h want=%h", {o_soft, o_symbol}, {m_pred, ref_sym(m_pred)});
    end
    do_pop(h);
  endtask

  task automatic test_reset_mid;
    logic [33:0] h, e;
    bit p;
    run_trig($urandom, 1, 1, 1'b0, p, h);
    m_dl = 20; m_al = 0; m_pred = $urandom;
    i_trigger = 1'b1;
    @(posedge clk); #1;
    i_trigger = 1'b0;
    repeat (4) @(posedge clk); #1;
    i_trigger = 1'b1;
    @(posedge clk); #1;
    i_trigger = 1'b0;
    tests_run++;
    if (o_overflow !== 1'b1 || o_fc_start !== 1'b1) begin
      fails++; $display("FAIL busy_trigger got=%b/%b want=1/1", o_overflow, o_fc_start);
    end
    #2 rstn = 1'b0;
    #1;
    tests_run++;
    if ({o_fc_start, o_valid, o_count, o_overflow, o_trig_ready} !== '0) begin
      fails++; $display("FAIL mid_reset got=%b/%b/%0d/%b/%b want=0/0/0/0/0",
                        o_fc_start, o_valid, o_count, o_overflow, o_trig_ready);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    run_trig($urandom, 2, 1, 1'b0, p, h);
    e = exp_q.pop_front();
    tests_run++;
    if (!o_valid || o_count !== 4'd1 || {o_soft, o_symbol} !== e) begin
      fails++; $display("FAIL post_reset got=%h/%0d want=%h/1", {o_soft, o_symbol}, o_count, e);
    end
    do_pop(h);
  endtask

  initial begin
    test_reset();
    test_single();
    test_slicer();
    test_full_overflow();
    test_push_pop();
    test_done_early();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
